// File: rtl/byte_arb_pkg.sv
// byte_arb_pkg: shared widths, FSM states and grantee encoding for byte_reg_arbiter
package byte_arb_pkg;
  localparam int REG_AW = 3;
  localparam int REG_DW = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, DONE} state_t;
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} gnt_t;
endpackage

// File: rtl/byte_reg_arbiter_if.sv
// byte_reg_arbiter_if: two requester ports plus the shared downstream register port
interface byte_reg_arbiter_if;
  import byte_arb_pkg::*;
  logic [REG_AW-1:0] a_address, b_address, out_address;
  logic a_read, a_write, b_read, b_write, out_read, out_write;
  logic [REG_DW-1:0] a_writedata, b_writedata, out_writedata;
  logic [REG_DW-1:0] a_readdata, b_readdata, out_readdata;
  logic a_waitrequest, b_waitrequest;
  modport slave (
    input a_address, a_read, a_write, a_writedata, b_address, b_read, b_write, b_writedata, out_readdata,
    output a_readdata, a_waitrequest, b_readdata, b_waitrequest, out_address, out_read, out_write, out_writedata
  );
  modport master (
    output a_address, a_read, a_write, a_writedata, b_address, b_read, b_write, b_writedata, out_readdata,
    input a_readdata, a_waitrequest, b_readdata, b_waitrequest, out_address, out_read, out_write, out_writedata
  );
endinterface

// File: rtl/byte_arb_grant.sv
// byte_arb_grant: picks the grantee; BYTE_ARB_FIXED_PRIO_EN selects fixed A-first priority instead of round-robin
module byte_arb_grant
  import byte_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  gnt_t last_grant,
  output gnt_t gnt
);
`ifdef BYTE_ARB_FIXED_PRIO_EN
  assign gnt = (a_req || !b_req) ? GNT_A : GNT_B;
`else
  assign gnt = (a_req && (!b_req || last_grant == GNT_B)) ? GNT_A : GNT_B;
`endif
endmodule

// File: rtl/byte_reg_arbiter.sv
// byte_reg_arbiter: serialises two requesters onto one byte register port with waitrequest stretching
module byte_reg_arbiter
  import byte_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  byte_reg_arbiter_if.slave bus
);
  state_t state, state_nx;
  gnt_t gnt, last_grant, pick;
  logic op_wr;
  logic [REG_AW-1:0] addr;
  logic [REG_DW-1:0] wdata, a_rd, b_rd;
  logic [1:0] cnt;
  logic a_req, b_req;
  assign a_req = bus.a_read | bus.a_write;
  assign b_req = bus.b_read | bus.b_write;
  byte_arb_grant u_grant (.a_req(a_req), .b_req(b_req), .last_grant(last_grant), .gnt(pick));
  always_comb begin
    state_nx = state == IDLE   ? ((a_req || b_req) ? ISSUE : IDLE) :
               state == ISSUE  ? (op_wr ? DONE : RDWAIT) :
               state == RDWAIT ? (cnt == 2'd0 ? DONE : RDWAIT) : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt <= GNT_A;
      last_grant <= GNT_B;
      op_wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      cnt <= 2'd0;
      a_rd <= '0;
      b_rd <= '0;
    end else begin
      if (state == IDLE && (a_req || b_req)) begin
        gnt <= pick;
        addr <= pick == GNT_A ? bus.a_address : bus.b_address;
        wdata <= pick == GNT_A ? bus.a_writedata : bus.b_writedata;
        op_wr <= pick == GNT_A ? bus.a_write : bus.b_write;
      end
      if (state == ISSUE) cnt <= 2'(READ_LATENCY - 1);
      if (state == RDWAIT) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd0 && gnt == GNT_A) a_rd <= bus.out_readdata;
        if (cnt == 2'd0 && gnt == GNT_B) b_rd <= bus.out_readdata;
      end
      if (state == DONE) last_grant <= gnt;
    end
  end
  // Strobes are decoded from the registered state, so they last exactly the ISSUE cycle
  assign bus.out_read = state == ISSUE && !op_wr;
  assign bus.out_write = state == ISSUE && op_wr;
  assign bus.out_address = addr;
  assign bus.out_writedata = wdata;
  assign bus.a_waitrequest = !(state == DONE && gnt == GNT_A);
  assign bus.b_waitrequest = !(state == DONE && gnt == GNT_B);
  assign bus.a_readdata = a_rd;
  assign bus.b_readdata = b_rd;
endmodule

// File: tb/tb_byte_reg_arbiter.sv
// tb_byte_reg_arbiter: directed stimulus with queued expectations checked by negedge monitors
module tb_byte_reg_arbiter;
  import byte_arb_pkg::*;
  localparam int RL = 2;
  typedef struct {bit is_rd; logic [7:0] data; int lat;} cpl_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  byte_reg_arbiter_if bus();
  byte_reg_arbiter #(.READ_LATENCY(RL)) dut (.clk(clk), .reset(reset), .bus(bus));
  int compared = 0, mismatched = 0, cyc = 0, a_start = 0, b_start = 0, rd_cnt = 0;
  bit live = 1'b0;
  cpl_t a_q[$], b_q[$], a_e, b_e;
  logic [10:0] wr_q[$];
  logic [2:0] rd_q[$];
  logic [7:0] mem [8] = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h5A, 8'h66, 8'h77, 8'h88};
  logic [7:0] pipe [RL];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= reset ? 8'h00 : bus.out_read ? mem[bus.out_address] : pipe[0];
    for (int i = 1; i < RL; i++) pipe[i] <= reset ? 8'h00 : pipe[i-1];
  end
  assign bus.out_readdata = pipe[RL-1];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (live) begin
    if (!bus.a_waitrequest) begin
      if (a_q.size() == 0) check("a_unexpected_done", 1, 0);
      else begin
        a_e = a_q.pop_front();
        if (a_e.is_rd) check("a_readdata", bus.a_readdata, a_e.data);
        if (a_e.lat != 0) check("a_latency", cyc - a_start + 1, a_e.lat);
      end
    end
    if (!bus.b_waitrequest) begin
      if (b_q.size() == 0) check("b_unexpected_done", 1, 0);
      else begin
        b_e = b_q.pop_front();
        if (b_e.is_rd) check("b_readdata", bus.b_readdata, b_e.data);
        if (b_e.lat != 0) check("b_latency", cyc - b_start + 1, b_e.lat);
      end
    end
    if (bus.out_write) begin
      if (wr_q.size() == 0) check("unexpected_out_write", 1, 0);
      else check("out_write", {bus.out_address, bus.out_writedata}, wr_q.pop_front());
    end
    if (bus.out_read) begin
      rd_cnt++;
      if (rd_q.size() == 0) check("unexpected_out_read", 1, 0);
      else check("out_read_addr", bus.out_address, rd_q.pop_front());
    end
  end
  task automatic req(bit side, bit rd, bit wr, logic [2:0] ad, logic [7:0] d);
    bit done = 1'b0;
    if (side) begin
      bus.b_read = rd; bus.b_write = wr; bus.b_address = ad; bus.b_writedata = d; b_start = cyc;
    end else begin
      bus.a_read = rd; bus.a_write = wr; bus.a_address = ad; bus.a_writedata = d; a_start = cyc;
    end
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = side ? !bus.b_waitrequest : !bus.a_waitrequest;
    end
    if (!done) check(side ? "b_timeout" : "a_timeout", 1, 0);
    @(posedge clk); #1;
    if (side) begin bus.b_read = 1'b0; bus.b_write = 1'b0; end
    else begin bus.a_read = 1'b0; bus.a_write = 1'b0; end
  endtask
  task automatic exp_cpl(bit side, bit is_rd, logic [7:0] d, int lat);
    cpl_t e;
    e.is_rd = is_rd; e.data = d; e.lat = lat;
    if (side) b_q.push_back(e); else a_q.push_back(e);
  endtask
  initial begin
    int r;
    {bus.a_read, bus.a_write, bus.b_read, bus.b_write} = 4'b0;
    {bus.a_address, bus.b_address, bus.a_writedata, bus.b_writedata} = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    live = 1'b1;
    check("reset_values", {bus.a_readdata, bus.b_readdata, bus.out_address, bus.out_writedata}, 0);
    repeat (10) begin
      @(negedge clk);
      check("idle", {bus.a_waitrequest, bus.b_waitrequest, bus.out_read, bus.out_write}, 4'b1100);
    end
    @(posedge clk); #1;
    wr_q.push_back({3'd5, 8'h3C}); exp_cpl(0, 0, 0, 3);
    req(0, 0, 1, 3'd5, 8'h3C);
    rd_q.push_back(3'd2); exp_cpl(1, 1, 8'hA5, 3 + RL);
    req(1, 1, 0, 3'd2, 8'h00);
    check("a_readdata_kept", bus.a_readdata, 0);
`ifdef BYTE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) wr_q.push_back({3'(i), 8'hA0 + 8'(i)});
    for (int i = 0; i < 3; i++) wr_q.push_back({3'(4 + i), 8'hB0 + 8'(i)});
`else
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back({3'(i), 8'hA0 + 8'(i)});
      wr_q.push_back({3'(4 + i), 8'hB0 + 8'(i)});
    end
`endif
    for (int i = 0; i < 3; i++) begin exp_cpl(0, 0, 0, 0); exp_cpl(1, 0, 0, 0); end
    fork
      for (int i = 0; i < 3; i++) req(0, 0, 1, 3'(i), 8'hA0 + 8'(i));
      for (int j = 0; j < 3; j++) req(1, 0, 1, 3'(4 + j), 8'hB0 + 8'(j));
    join
    check("contention_drained", wr_q.size(), 0);
    r = rd_cnt;
    wr_q.push_back({3'd1, 8'h77}); exp_cpl(0, 0, 0, 3);
    req(0, 1, 1, 3'd1, 8'h77);
    check("rw_no_read", rd_cnt, r);
    rd_q.push_back(3'd4); exp_cpl(0, 1, 8'h5A, 3 + RL);
    req(0, 1, 0, 3'd4, 8'h00);
    rd_q.push_back(3'd3);
    bus.a_read = 1'b1; bus.a_address = 3'd3;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; bus.a_read = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mid_read", {bus.a_waitrequest, bus.a_readdata}, {1'b1, 8'h00});
    repeat (10) begin
      @(negedge clk);
      check("post_reset_quiet", {bus.out_read, bus.out_write, bus.a_waitrequest}, 3'b001);
    end
    check("queues_drained", a_q.size() + b_q.size() + wr_q.size() + rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
